metronome_beat_scheduler: RTL and testbench

- Sequences the metronome beat-display path: holds the current BPM and steps it on up/down requests.
- Converts BPM to a beat period in clock cycles with an on-block sequential divider.
- Runs the beat-phase counter and emits the one-cycle beat trigger plus the 34-bit phase count consumed by the display block.
- Sits between the debounced button inputs and the display/LED logic.

---
 rtl/metronome_beat_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_metronome_beat_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/metronome_beat_scheduler.sv
// Metronome beat scheduler: BPM register, sequential BPM-to-period divider and beat-phase counter.
// Optional bar accent output is built when METRONOME_ACCENT_EN is defined.
module metronome_beat_scheduler #(
    parameter int CLK_FREQ      = 50000000,
    parameter int BPM_MIN       = 30,
    parameter int BPM_MAX       = 300,
    parameter int BPM_DEFAULT   = 120,
    parameter int BPM_STEP      = 1,
    parameter int BEATS_PER_BAR = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic        i_bpm_up,
    input  logic        i_bpm_down,
    output logic        o_trigger,
    output logic [33:0] o_bpm_counter,
    output logic [8:0]  o_bpm_value,
    output logic        o_running,
    output logic        o_div_busy,
    output logic        o_accent
);

    localparam logic [33:0] DIVIDEND       = 34'(64'(CLK_FREQ) * 64'd60);
    localparam logic [33:0] PERIOD_DEFAULT = 34'((64'(CLK_FREQ) * 64'd60) / 64'(BPM_DEFAULT));
    localparam logic [9:0]  MIN_W          = 10'(BPM_MIN);
    localparam logic [9:0]  MAX_W          = 10'(BPM_MAX);
    localparam logic [9:0]  STEP_W         = 10'(BPM_STEP);
    localparam logic [8:0]  BPM_RESET      = 9'(BPM_DEFAULT);

    typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;
    typedef enum logic {IDLE, RUN} beat_state_t;

    div_state_t  div_state, div_next;
    beat_state_t beat_state, beat_next;

    logic [9:0]  bpm_up_val, bpm_dn_val;
    logic [8:0]  bpm_next;
    logic        bpm_change;

    logic        div_req, div_pending, div_restart, div_load, div_commit;
    logic [8:0]  rem;
    logic [9:0]  rem_shift;
    logic [8:0]  rem_diff;
    logic [33:0] quo;
    logic [5:0]  iter;

    logic [33:0] period, next_period;
    logic        next_valid;
    logic        start_go, stop_go, wrap;

    // BPM request decode: opposing requests cancel, result is clamped to the legal range.
    // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        bpm_up_val = {1'b0, o_bpm_value} + STEP_W;
        if (bpm_up_val > MAX_W) bpm_up_val = MAX_W;
        bpm_dn_val = ({1'b0, o_bpm_value} < MIN_W + STEP_W) ? MIN_W : {1'b0, o_bpm_value} - STEP_W;
        bpm_next   = o_bpm_value;
        if (i_bpm_up && !i_bpm_down)      bpm_next = bpm_up_val[8:0];
        else if (i_bpm_down && !i_bpm_up) bpm_next = bpm_dn_val[8:0];
        bpm_change = (bpm_next != o_bpm_value);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)        o_bpm_value <= BPM_RESET;
        else if (bpm_change) o_bpm_value <= bpm_next;
    end

    // Divider FSM
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) div_state <= DIV_IDLE;
        else          div_state <= div_next;
    end

    assign div_restart = div_pending || bpm_change;

    always_comb begin
        div_next = div_state;
        case (div_state)
            DIV_IDLE: if (div_req)        div_next = DIV_RUN;
            DIV_RUN:  if (iter == 6'd33)  div_next = DIV_DONE;
            DIV_DONE: div_next = div_restart ? DIV_RUN : DIV_IDLE;
            default:  div_next = DIV_IDLE;
        endcase
    end

    always_comb begin
        o_div_busy = (div_state != DIV_IDLE);
    end

    assign div_load   = (div_state == DIV_IDLE && div_req) || (div_state == DIV_DONE && div_restart);
    assign div_commit = (div_state == DIV_DONE) && !div_restart;
    assign rem_shift  = {rem, quo[33]};
    assign rem_diff   = rem_shift[8:0] - o_bpm_value;

    // Restoring divide, one quotient bit per cycle; the divisor is read live so a retrigger sees the latest BPM.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            div_req     <= 1'b0;
            div_pending <= 1'b0;
            rem         <= '0;
            quo         <= '0;
            iter        <= '0;
        end else begin
            if (div_load)                                div_req <= 1'b0;
            else if (bpm_change && div_state == DIV_IDLE) div_req <= 1'b1;

            if (div_state == DIV_RUN && bpm_change) div_pending <= 1'b1;
            else if (div_load)                      div_pending <= 1'b0;

            if (div_load) begin
                rem  <= '0;
                quo  <= DIVIDEND;
                iter <= '0;
            end else if (div_state == DIV_RUN) begin
                if (rem_shift >= {1'b0, o_bpm_value}) begin
                    rem <= rem_diff;
                    quo <= {quo[32:0], 1'b1};
                end else begin
                    rem <= rem_shift[8:0];
                    quo <= {quo[32:0], 1'b0};
                end
                iter <= iter + 6'd1;
            end
        end
    end

    // Beat FSM
    assign start_go = (beat_state == IDLE) && i_start && !i_stop;
    assign stop_go  = (beat_state == RUN) && i_stop;
    assign wrap     = (beat_state == RUN) && !i_stop && (o_bpm_counter == period - 34'd1);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) beat_state <= IDLE;
        else          beat_state <= beat_next;
    end

    always_comb begin
        beat_next = beat_state;
        case (beat_state)
            IDLE:    if (start_go) beat_next = RUN;
            RUN:     if (i_stop)   beat_next = IDLE;
            default: beat_next = IDLE;
        endcase
    end

    always_comb begin
        o_running = (beat_state == RUN);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_bpm_counter <= '0;
            o_trigger     <= 1'b0;
        end else if (start_go || wrap) begin
            o_bpm_counter <= '0;
            o_trigger     <= 1'b1;
        end else if (beat_state == RUN && !stop_go) begin
            o_bpm_counter <= o_bpm_counter + 34'd1;
            o_trigger     <= 1'b0;
        end else begin
            o_bpm_counter <= '0;
            o_trigger     <= 1'b0;
        end
    end

    // A period computed while running waits for the beat boundary so the current beat keeps its length.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            period      <= PERIOD_DEFAULT;
            next_period <= '0;
            next_valid  <= 1'b0;
        end else if (div_commit && (beat_state == IDLE || wrap)) begin
            period     <= quo;
            next_valid <= 1'b0;
        end else if (div_commit) begin
            next_period <= quo;
            next_valid  <= 1'b1;
        end else if (next_valid && (wrap || stop_go)) begin
            period     <= next_period;
            next_valid <= 1'b0;
        end
    end

`ifdef METRONOME_ACCENT_EN
    localparam int             BAR_W    = (BEATS_PER_BAR > 1) ? $clog2(BEATS_PER_BAR) : 1;
    localparam logic [BAR_W-1:0] BAR_LAST = BAR_W'(BEATS_PER_BAR - 1);

    // bar_count holds the index of the next beat to be triggered.
    logic [BAR_W-1:0] bar_count;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            bar_count <= '0;
            o_accent  <= 1'b0;
        end else if (start_go) begin
            bar_count <= (BAR_LAST == '0) ? '0 : BAR_W'(1);
            o_accent  <= 1'b1;
        end else if (stop_go) begin
            bar_count <= '0;
            o_accent  <= 1'b0;
        end else if (wrap) begin
            bar_count <= (bar_count == BAR_LAST) ? '0 : bar_count + BAR_W'(1);
            o_accent  <= (bar_count == '0);
        end else begin
            o_accent  <= 1'b0;
        end
    end
`else
    assign o_accent = 1'b0;
`endif

endmodule

// File: tb/tb_metronome_beat_scheduler.sv
// Directed bench for metronome_beat_scheduler at CLK_FREQ=1000 (120 BPM -> 500-cycle beats).
module tb_metronome_beat_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop, up, down;
    logic        trigger, running, busy, accent;
    logic [33:0] counter;
    logic [8:0]  bpm;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    metronome_beat_scheduler #(
        .CLK_FREQ(1000), .BPM_MIN(30), .BPM_MAX(300), .BPM_DEFAULT(120),
        .BPM_STEP(1), .BEATS_PER_BAR(4)
    ) dut (
        .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_stop(stop),
        .i_bpm_up(up), .i_bpm_down(down), .o_trigger(trigger),
        .o_bpm_counter(counter), .o_bpm_value(bpm), .o_running(running),
        .o_div_busy(busy), .o_accent(accent)
    );

    typedef struct {
        logic up, down, start, stop;
        int   bpm;
        logic running, busy, trig;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic u, input logic d, input logic sa, input logic so);
        up = u; down = d; start = sa; stop = so;
        tick();
        up = 0; down = 0; start = 0; stop = 0;
    endtask

    task automatic do_reset();
        up = 0; down = 0; start = 0; stop = 0;
        rst_n = 0;
        repeat (2) tick();
        rst_n = 1;
        tick();
    endtask

    task automatic wait_trig(input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!trigger && n < budget);
        if (!trigger) n = -1;
    endtask

    task automatic wait_idle(input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (busy && n < budget);
        if (busy) n = -1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n;
        int  elapsed;
        logic ok;

        //                 up down start stop bpm  run busy trig
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 120, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 120, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 120, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 119, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 119, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 119, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 119, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 119, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 120, 1'b0, 1'b1, 1'b0};

        // Reset state, first beat and 120 BPM cadence
        do_reset();
        check("rst_trigger", trigger, 0);
        check("rst_counter", counter, 0);
        check("rst_bpm", bpm, 120);
        check("rst_running", running, 0);
        check("rst_busy", busy, 0);
        check("rst_accent", accent, 0);
        pulse(0, 0, 1, 0);
        check("first_trigger", trigger, 1);
        check("first_counter", counter, 0);
        check("first_running", running, 1);
        ok = 1;
        for (int i = 1; i < 500; i++) begin
            tick();
            if (counter != 34'(i) || trigger) ok = 0;
        end
        check("counter_sweep_0_499", ok, 1);
        tick();
        check("wrap_trigger", trigger, 1);
        check("wrap_counter", counter, 0);
        wait_trig(600, n);
        check("period_120_a", n, 500);
        wait_trig(600, n);
        check("period_120_b", n, 500);

        // Single-cycle vector table
        do_reset();
        for (int i = 0; i < 9; i++) begin
            pulse(vecs[i].up, vecs[i].down, vecs[i].start, vecs[i].stop);
            check($sformatf("vec%0d_bpm", i), bpm, vecs[i].bpm);
            check($sformatf("vec%0d_running", i), running, vecs[i].running);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
            check($sformatf("vec%0d_trigger", i), trigger, vecs[i].trig);
            if (i == 6) check("vec6_start_ignored_counter", counter, 1);
        end
        // 119 divide is discarded, then a full 35-cycle rerun for 120
        wait_idle(200, n);
        check("pending_rerun_cycles", n, 66);
        pulse(0, 0, 1, 0);
        wait_trig(600, n);
        check("period_after_rerun", n, 500);

        // 60 spaced up-steps while stopped -> 180 BPM, period 333
        do_reset();
        for (int i = 0; i < 60; i++) begin
            if (i > 0) tick();
            pulse(1, 0, 0, 0);
        end
        check("burst_up_bpm", bpm, 180);
        ok = 1;
        for (int i = 0; i < 35; i++) begin
            tick();
            if (!busy) ok = 0;
        end
        check("busy_held_36", ok, 1);
        wait_idle(300, n);
        check("burst_up_settled", n > 0, 1);
        pulse(0, 0, 1, 0);
        check("start_180_trigger", trigger, 1);
        wait_trig(600, n);
        check("period_180", n, 333);

        // Slow down to 60 BPM mid-beat: current beat keeps 500, later beats 1000
        do_reset();
        pulse(0, 0, 1, 0);
        repeat (100) tick();
        check("mid_beat_counter", counter, 100);
        elapsed = 100;
        down = 1;
        repeat (60) begin
            tick();
            elapsed++;
        end
        down = 0;
        check("burst_down_bpm", bpm, 60);
        wait_trig(800, n);
        check("old_beat_length", elapsed + n, 500);
        wait_trig(1200, n);
        check("period_60_a", n, 1000);
        wait_trig(1200, n);
        check("period_60_b", n, 1000);

        // Upper clamp and single-divide latency
        do_reset();
        up = 1;
        repeat (180) tick();
        up = 0;
        wait_idle(500, n);
        check("climb_settled", n > 0, 1);
        check("bpm_at_max", bpm, 300);
        pulse(1, 0, 0, 0);
        check("clamp_bpm", bpm, 300);
        ok = 1;
        for (int i = 0; i < 40; i++) begin
            if (busy) ok = 0;
            tick();
        end
        check("clamp_no_divide", ok, 1);
        pulse(0, 1, 0, 0);
        check("step_down_bpm", bpm, 299);
        wait_idle(100, n);
        check("div_latency", n, 36);

        // Stop mid-beat; start while running is ignored
        do_reset();
        pulse(0, 0, 1, 0);
        repeat (100) tick();
        pulse(0, 0, 1, 0);
        check("restart_ignored_counter", counter, 101);
        check("restart_ignored_trigger", trigger, 0);
        repeat (149) tick();
        check("pre_stop_counter", counter, 250);
        pulse(0, 0, 0, 1);
        check("stop_counter", counter, 0);
        check("stop_running", running, 0);
        check("stop_trigger", trigger, 0);
        ok = 1;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (trigger || counter != 0) ok = 0;
        end
        check("stopped_quiet", ok, 1);

        // Reset mid-divide
        do_reset();
        pulse(1, 0, 0, 0);
        repeat (10) tick();
        check("mid_div_busy", busy, 1);
        check("mid_div_bpm", bpm, 121);
        #2 rst_n = 0;
        #1;
        check("async_rst_bpm", bpm, 120);
        check("async_rst_busy", busy, 0);
        tick();
        rst_n = 1;
        repeat (50) tick();
        check("post_rst_busy", busy, 0);
        pulse(0, 0, 1, 0);
        wait_trig(600, n);
        check("post_rst_period", n, 500);

`ifdef METRONOME_ACCENT_EN
        // Accent on beats 1, 5, 9; bar restarts after stop/start
        do_reset();
        pulse(0, 0, 1, 0);
        check("accent_beat1", accent, 1);
        for (int b = 2; b <= 9; b++) begin
            wait_trig(600, n);
            check($sformatf("accent_beat%0d", b), accent, ((b - 1) % 4 == 0) ? 1 : 0);
        end
        wait_trig(600, n);
        check("accent_beat10", accent, 0);
        pulse(0, 0, 0, 1);
        pulse(0, 0, 1, 0);
        check("accent_after_restart", accent, 1);
        wait_trig(600, n);
        check("accent_after_restart_2", accent, 0);
`else
        do_reset();
        pulse(0, 0, 1, 0);
        ok = 1;
        for (int i = 0; i < 1100; i++) begin
            if (accent) ok = 0;
            tick();
        end
        check("accent_tied_low", ok, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
